// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing defaults shared by the sync generator and its users.
package vga_timing_pkg;
  localparam int CNT_W      = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
  localparam int V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

  // Half-open range test on a raster count.
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction
endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-clock enable: divides the system clock by CLK_DIV, pix_en high one clock in CLK_DIV.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  output logic pix_en
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;

  // pix_en is registered so it is low in reset even when CLK_DIV==1.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_en_d  = (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v counters, registered sync/active/frame_start decoded from next-state counts.
// Optional VGA_FRAME_CNT_EN adds a 16-bit wrapping frame counter port.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             v_sync,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic pix_en_w;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clock  (clock),
    .reset  (reset),
    .pix_en (pix_en_w)
  );

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic active_q, active_d;
  logic v_sync_q, v_sync_d;
  logic vga_hs_q, vga_hs_d;
  logic vga_vs_q, vga_vs_d;
  logic frame_start_q, frame_start_d;

  // Decode from x_d/y_d so every registered flag lines up with the count it describes.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en_w) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    active_d      = (x_d < H_ACT) && (y_d < V_ACT);
    v_sync_d      = in_range(y_d, V_SS, V_SE);
    vga_hs_d      = in_range(x_d, H_SS, H_SE) ^ ~SYNC_POL;
    vga_vs_d      = v_sync_d ^ ~SYNC_POL;
    frame_start_d = pix_en_w && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      active_q      <= 1'b0;
      v_sync_q      <= 1'b0;
      vga_hs_q      <= ~SYNC_POL;
      vga_vs_q      <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      v_sync_q      <= v_sync_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pix_en      = pix_en_w;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign v_sync      = v_sync_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign frame_start = frame_start_q;
endmodule
